// File: rtl/reg_fifo_p.sv
// Register-mapped packet FIFO driven by regwrap access enables: programmable
// packet length, level/threshold reporting, sticky error flags, flush and read-complete.
module reg_fifo_p #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int LEN_W     = $clog2(DEPTH + 1),
  parameter int AF_THRESH = DEPTH - 1,
  parameter int AE_THRESH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] data_in,
  input  logic             rd_en,
  output logic [WIDTH-1:0] data_out,
  input  logic             length_wr_en,
  input  logic [LEN_W-1:0] length_in,
  input  logic             length_rd_en,
  output logic [LEN_W-1:0] length_out,
  input  logic             flush,
  input  logic             clr_flags,
  output logic [LEN_W-1:0] level,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic             overflow,
  output logic             underflow,
  output logic             read_complete
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);
  localparam logic [LEN_W-1:0] AF_L    = LEN_W'(AF_THRESH);
  localparam logic [LEN_W-1:0] AE_L    = LEN_W'(AE_THRESH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [LEN_W-1:0] r_level;
  logic [LEN_W-1:0] r_length;
  logic [LEN_W-1:0] r_length_out;
  logic [LEN_W-1:0] r_rd_cnt;
  logic [WIDTH-1:0] r_data_out;
  logic             r_overflow;
  logic             r_underflow;
  logic             r_read_complete;

  logic [LEN_W-1:0] w_eff_len;
  logic [LEN_W-1:0] w_rd_cnt_nxt;
  logic             w_full;
  logic             w_empty;
  logic             w_wr_acc;
  logic             w_rd_acc;
  logic             w_clr_cnt;

  // Out-of-range lengths stay stored as written and are clamped only here.
  always_comb begin
    // NOTE: assign a default before any condition so always_comb never infers a latch.
    w_eff_len = r_length;
    if (r_length == '0 || r_length > DEPTH_L) w_eff_len = DEPTH_L;
  end

  assign w_full       = (r_level >= w_eff_len);
  assign w_empty      = (r_level == '0);
  assign w_wr_acc     = wr_en && !w_full && !flush;
  assign w_rd_acc     = rd_en && !w_empty && !flush;
  assign w_clr_cnt    = flush || w_wr_acc || length_wr_en;
  assign w_rd_cnt_nxt = r_rd_cnt + LEN_W'(1);

  // NOTE: the storage array has no reset; the pointers and level define which entries are valid.
  always_ff @(posedge clk) begin
    if (w_wr_acc) r_mem[r_wr_ptr] <= data_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_level         <= '0;
      r_length        <= '0;
      r_length_out    <= '0;
      r_rd_cnt        <= '0;
      r_data_out      <= '0;
      r_overflow      <= 1'b0;
      r_underflow     <= 1'b0;
      r_read_complete <= 1'b0;
    end else begin
      if (flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
        r_level  <= '0;
      end else begin
        if (w_wr_acc) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
        if (w_rd_acc) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        r_level <= r_level + LEN_W'(w_wr_acc) - LEN_W'(w_rd_acc);
      end

      if (w_rd_acc)     r_data_out   <= r_mem[r_rd_ptr];
      if (length_wr_en) r_length     <= length_in;
      if (length_rd_en) r_length_out <= r_length;

      // A same-cycle error event beats clr_flags; flush beats everything.
      if (flush)                r_overflow <= 1'b0;
      else if (wr_en && w_full) r_overflow <= 1'b1;
      else if (clr_flags)       r_overflow <= 1'b0;

      if (flush)                 r_underflow <= 1'b0;
      else if (rd_en && w_empty) r_underflow <= 1'b1;
      else if (clr_flags)        r_underflow <= 1'b0;

      if (w_clr_cnt) begin
        r_rd_cnt        <= '0;
        r_read_complete <= 1'b0;
      end else if (w_rd_acc) begin
        r_rd_cnt <= w_rd_cnt_nxt;
        if (w_rd_cnt_nxt == w_eff_len) r_read_complete <= 1'b1;
      end
    end
  end

  assign data_out      = r_data_out;
  assign length_out    = r_length_out;
  assign level         = r_level;
  assign full          = w_full;
  assign empty         = w_empty;
  assign almost_full   = (r_level >= AF_L);
  assign almost_empty  = (r_level <= AE_L);
  assign overflow      = r_overflow;
  assign underflow     = r_underflow;
  assign read_complete = r_read_complete;

endmodule

// File: tb/tb_reg_fifo_p.sv
// Directed bench for reg_fifo_p: stimulus queues expected read data, a monitor
// compares data_out one cycle after every rd_en; flags are checked inline.
module tb_reg_fifo_p;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int LEN_W = 5;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             wr_en = 1'b0;
  logic [WIDTH-1:0] data_in = '0;
  logic             rd_en = 1'b0;
  logic [WIDTH-1:0] data_out;
  logic             length_wr_en = 1'b0;
  logic [LEN_W-1:0] length_in = '0;
  logic             length_rd_en = 1'b0;
  logic [LEN_W-1:0] length_out;
  logic             flush = 1'b0;
  logic             clr_flags = 1'b0;
  logic [LEN_W-1:0] level;
  logic             full, empty, almost_full, almost_empty;
  logic             overflow, underflow, read_complete;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] exp_q[$];

  reg_fifo_p #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .data_in(data_in),
    .rd_en(rd_en), .data_out(data_out),
    .length_wr_en(length_wr_en), .length_in(length_in),
    .length_rd_en(length_rd_en), .length_out(length_out),
    .flush(flush), .clr_flags(clr_flags),
    .level(level), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .overflow(overflow), .underflow(underflow),
    .read_complete(read_complete)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_lvl(input string tag, input int lvl, input bit f, input bit e);
    check({tag, "_level"}, 32'(level), 32'(lvl));
    check({tag, "_full"},  32'(full),  32'(f));
    check({tag, "_empty"}, 32'(empty), 32'(e));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [WIDTH-1:0] d);
    wr_en = 1'b1; data_in = d;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [WIDTH-1:0] exp);
    exp_q.push_back(exp);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  task automatic wrlen(input logic [LEN_W-1:0] l);
    length_wr_en = 1'b1; length_in = l;
    tick();
    length_wr_en = 1'b0;
  endtask

  task automatic rdlen();
    length_rd_en = 1'b1;
    tick();
    length_rd_en = 1'b0;
  endtask

  // Monitor: data_out is valid one cycle after each rd_en edge.
  initial begin
    forever begin
      @(posedge clk);
      if (rd_en && !reset) begin
        #2;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL data_out_unexpected actual=0x%0h required=none", data_out);
        end else begin
          check("data_out", 32'(data_out), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk_lvl("rst", 0, 1'b0, 1'b1);
    check("rst_ae",   32'(almost_empty),  32'(1));
    check("rst_af",   32'(almost_full),   32'(0));
    check("rst_ovf",  32'(overflow),      32'(0));
    check("rst_unf",  32'(underflow),     32'(0));
    check("rst_rc",   32'(read_complete), 32'(0));
    check("rst_dout", 32'(data_out),      32'(0));
    check("rst_lout", 32'(length_out),    32'(0));

    // Length 3 packet, fill to full, overflow on the fourth write.
    wrlen(5'd3);
    rdlen();
    check("t1_lout", 32'(length_out), 32'(3));
    wr(8'h01); wr(8'h02); wr(8'h03);
    chk_lvl("t1", 3, 1'b1, 1'b0);
    check("t1_af", 32'(almost_full), 32'(0));
    wr(8'h04);
    check("t2_ovf", 32'(overflow), 32'(1));
    check("t2_level", 32'(level), 32'(3));
    rd(8'h01); rd(8'h02);
    check("t2_rc_early", 32'(read_complete), 32'(0));
    rd(8'h03);
    check("t2_rc", 32'(read_complete), 32'(1));
    chk_lvl("t2", 0, 1'b0, 1'b1);

    // Underflow holds data_out, clr_flags, write clears read_complete.
    rd(8'h03);
    check("t3_unf", 32'(underflow), 32'(1));
    clr_flags = 1'b1; tick(); clr_flags = 1'b0;
    check("t3_unf_clr", 32'(underflow), 32'(0));
    check("t3_ovf_clr", 32'(overflow), 32'(0));
    check("t3_rc_hold", 32'(read_complete), 32'(1));
    wr(8'hAA);
    check("t3_rc_clr", 32'(read_complete), 32'(0));
    check("t3_level", 32'(level), 32'(1));
    rd(8'hAA);

    // Length 0 means DEPTH: fill 16, then exercise simultaneous access.
    wrlen(5'd0);
    for (int i = 0; i < 16; i++) begin
      wr(WIDTH'(i));
      if (i == 14) begin
        chk_lvl("t4_15", 15, 1'b0, 1'b0);
        check("t4_af", 32'(almost_full), 32'(1));
      end
    end
    chk_lvl("t4_16", 16, 1'b1, 1'b0);
    // At full, the read occurs and the write is dropped as an overflow.
    wr_en = 1'b1; rd_en = 1'b1; data_in = 8'hEE; exp_q.push_back(8'h00);
    tick();
    check("t4_sim_full_ovf", 32'(overflow), 32'(1));
    chk_lvl("t4_sim_full", 15, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      data_in = WIDTH'(8'h10 + i);
      exp_q.push_back((i < 15) ? WIDTH'(i + 1) : WIDTH'(8'h10 + i - 15));
      tick();
      check("t4_sim_level", 32'(level), 32'(15));
    end
    wr_en = 1'b0; rd_en = 1'b0;
    flush = 1'b1; tick(); flush = 1'b0;
    chk_lvl("t4_flush", 0, 1'b0, 1'b1);
    check("t4_flush_ovf", 32'(overflow), 32'(0));
    check("t4_flush_dout", 32'(data_out), 32'(8'h14));

    // Flush beats a same-cycle write.
    for (int i = 0; i < 5; i++) wr(WIDTH'(8'h50 + i));
    check("t5_fill", 32'(level), 32'(5));
    flush = 1'b1; wr_en = 1'b1; data_in = 8'h99;
    tick();
    flush = 1'b0; wr_en = 1'b0;
    chk_lvl("t5_flush", 0, 1'b0, 1'b1);
    wr(8'h77);
    check("t5_after", 32'(level), 32'(1));
    rd(8'h77);

    // Asynchronous reset mid-burst, checked between clock edges.
    wr_en = 1'b1; data_in = 8'h31; tick();
    data_in = 8'h32; tick();
    #3 reset = 1'b1;
    #1;
    chk_lvl("t5_arst", 0, 1'b0, 1'b1);
    check("t5_arst_ae",   32'(almost_empty), 32'(1));
    check("t5_arst_dout", 32'(data_out),     32'(0));
    check("t5_arst_lout", 32'(length_out),   32'(0));
    wr_en = 1'b0;
    #1 reset = 1'b0;
    tick();

    // Shrinking the length below the level: full, yet all data readable.
    wrlen(5'd8);
    for (int i = 0; i < 6; i++) wr(WIDTH'(8'h60 + i));
    chk_lvl("t6_fill", 6, 1'b0, 1'b0);
    wrlen(5'd4);
    chk_lvl("t6_shrink", 6, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      rd(WIDTH'(8'h60 + i));
      if (i == 3) check("t6_rc", 32'(read_complete), 32'(1));
    end
    check("t6_empty", 32'(empty), 32'(1));

    // Out-of-range length is stored as written.
    wrlen(5'd20);
    rdlen();
    check("t7_lout", 32'(length_out), 32'(20));

    tick(); tick();
    check("exp_q_drained", 32'(exp_q.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
